// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_EN   = 2'd2,
    WAIT_DONE = 2'd3
  } spi_seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with extra-bit pointers for full/empty.
// Latency: a push is visible on rd_data the cycle after it is written.
// Backpressure: writes while full and reads while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Status: equal low bits with differing wrap bit means full.
  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count   = wr_ptr_q - rd_ptr_q;
    rd_data = mem_q[rd_ptr_q[AW-1:0]];
    do_wr   = wr_en && !full;
    do_rd   = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Pointer registers; wrap falls out of the natural AW+1 bit overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, no reset needed since empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds bytes from a TX FIFO to an SPI driver one at a time and collects replies in an RX FIFO.
// Latency: IDLE + LAUNCH + driver transfer + one done cycle per byte; reply readable next cycle.
// Backpressure: tx_ready drops when TX is full; no launch while RX is full, so nothing is dropped.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SPI_DATA_W-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [SPI_DATA_W-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [SPI_DATA_W-1:0]         drv_data_in,
  output logic                          drv_start,
  input  logic                          drv_en,
  input  logic [SPI_DATA_W-1:0]         drv_data_out,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  spi_seq_state_t        state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic [SPI_DATA_W-1:0] dat_q, dat_d;

  logic                  tx_pop, rx_push, launch;
  logic [SPI_DATA_W-1:0] tx_head;
  logic                  tx_full, tx_empty;
  logic [CW-1:0]         tx_count;
  logic [CW-1:0]         rx_count;
  logic                  rx_full, rx_empty;

  sync_fifo #(.WIDTH(SPI_DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  sync_fifo #(.WIDTH(SPI_DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_push),
    .wr_data (drv_data_out),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // Next-state logic: one byte in flight; RX space is reserved before launching.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    dat_d   = dat_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty && (rx_count < CW'(FIFO_DEPTH))) begin
          tx_pop  = 1'b1;
          dat_d   = tx_head;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        launch  = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_EN;
      end
      WAIT_EN: begin
        if (drv_en) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          // Driver never acknowledged: drop the byte, flag it, move on.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!drv_en) begin
          rx_push = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, timeout counter, sticky error and the launched byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Output mapping; start is masked during reset so a reset in LAUNCH never pulses it.
  always_comb begin
    drv_start   = launch && !rst;
    drv_data_in = dat_q;
    busy        = (state_q != IDLE);
    err_timeout = err_q;
    tx_ready    = !tx_full;
    rx_valid    = !rx_empty;
    tx_level    = tx_count;
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
module tb_spi_byte_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] drv_data_in;
  logic       drv_start;
  logic       drv_en;
  logic [7:0] drv_data_out;
  logic       busy;
  logic       err_timeout;
  logic [2:0] tx_level;

  int checks = 0;
  int errors = 0;

  spi_byte_sequencer #(.FIFO_DEPTH(4), .START_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .drv_data_in  (drv_data_in),
    .drv_start    (drv_start),
    .drv_en       (drv_en),
    .drv_data_out (drv_data_out),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .tx_level     (tx_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver model: on start, drv_en high for 16 cycles, then reply = byte ^ 0x99.
  logic       drv_never;
  logic [7:0] drv_latched;
  int         drv_cnt;
  int         cyc = 0;
  int         start_cnt = 0;
  logic [7:0] start_log [32];
  int         start_cyc [32];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (drv_start) begin
      if (start_cnt < 32) begin
        start_log[start_cnt] <= drv_data_in;
        start_cyc[start_cnt] <= cyc;
      end
      start_cnt <= start_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      drv_en       <= 1'b0;
      drv_cnt      <= 0;
      drv_data_out <= 8'h00;
    end else if (drv_start && !drv_never) begin
      drv_en      <= 1'b1;
      drv_cnt     <= 0;
      drv_latched <= drv_data_in;
    end else if (drv_en) begin
      if (drv_cnt == 15) begin
        drv_en       <= 1'b0;
        drv_data_out <= drv_latched ^ 8'h99;
      end
      drv_cnt <= drv_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    errors++;
    $display("FAIL %s wait expired observed=timeout expected=event", tag);
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) tmo("push");
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!rx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_valid) tmo(tag);
    else chk(tag, 32'(rx_data), exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    rx_ready  = 1'b0;
    drv_never = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy",     32'(busy),        0);
    chk("rst_start",    32'(drv_start),   0);
    chk("rst_data_in",  32'(drv_data_in), 0);
    chk("rst_err",      32'(err_timeout), 0);
    chk("rst_rx_valid", 32'(rx_valid),    0);
    chk("rst_tx_ready", 32'(tx_ready),    1);
    chk("rst_tx_level", 32'(tx_level),    0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte A5 -> reply 3C
    push(8'hA5);
    n = 0;
    while (!(start_cnt == 1 && !busy && rx_valid) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("single_wait");
    chk("single_starts",  start_cnt, 1);
    chk("single_data_in", 32'(start_log[0]), 'hA5);
    chk("single_rx_vld",  32'(rx_valid), 1);
    chk("single_rx_dat",  32'(rx_data), 'h3C);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("single_popped", 32'(rx_valid), 0);

    // Back-to-back 01..04
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    n = 0;
    while (!(start_cnt == 5 && !busy) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) tmo("b2b_wait");
    chk("b2b_start1", 32'(start_log[1]), 'h01);
    chk("b2b_start2", 32'(start_log[2]), 'h02);
    chk("b2b_start3", 32'(start_log[3]), 'h03);
    chk("b2b_start4", 32'(start_log[4]), 'h04);
    // 17-cycle transfer (16 drv_en cycles + done cycle) plus IDLE and LAUNCH
    chk("b2b_space12", start_cyc[2] - start_cyc[1], 19);
    chk("b2b_space23", start_cyc[3] - start_cyc[2], 19);
    chk("b2b_space34", start_cyc[4] - start_cyc[3], 19);
    chk("b2b_tx_level", 32'(tx_level), 0);
    pop_check("b2b_rx1", 'h98);
    pop_check("b2b_rx2", 'h9B);
    pop_check("b2b_rx3", 'h9A);
    pop_check("b2b_rx4", 'h9D);
    chk("b2b_rx_empty", 32'(rx_valid), 0);

    // RX full: six bytes, consumer stalled
    push(8'h10);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    push(8'h14);
    chk("full_tx_ready", 32'(tx_ready), 0);
    push(8'h15);
    n = 0;
    while (!(start_cnt == 9 && !busy) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) tmo("full_wait");
    repeat (60) @(negedge clk);
    chk("full_starts",   start_cnt, 9);
    chk("full_tx_level", 32'(tx_level), 2);
    chk("full_rx_vld",   32'(rx_valid), 1);
    pop_check("full_rx1", 'h89);
    pop_check("full_rx2", 'h88);
    pop_check("full_rx3", 'h8B);
    pop_check("full_rx4", 'h8A);
    pop_check("full_rx5", 'h8D);
    pop_check("full_rx6", 'h8C);
    chk("full_starts_end", start_cnt, 11);

    // Start timeout: driver ignores the start
    drv_never = 1'b1;
    push(8'h55);
    n = 0;
    while (start_cnt != 12 && n < 100) begin @(negedge clk); n++; end
    if (start_cnt != 12) tmo("tmo_start");
    n = 0;
    while (!err_timeout && n < 40) begin @(negedge clk); n++; end
    chk("tmo_cycles", n, 15);
    chk("tmo_busy",   32'(busy), 0);
    chk("tmo_no_rx",  32'(rx_valid), 0);
    drv_never = 1'b0;
    push(8'h66);
    n = 0;
    while (!(start_cnt == 13 && !busy) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("tmo_next_wait");
    chk("tmo_next_byte", 32'(start_log[12]), 'h66);
    pop_check("tmo_next_rx", 'hFF);
    chk("tmo_sticky", 32'(err_timeout), 1);

    // Reset during WAIT_DONE
    push(8'h77);
    n = 0;
    while (start_cnt != 14 && n < 100) begin @(negedge clk); n++; end
    if (start_cnt != 14) tmo("rstmid_start");
    repeat (5) @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy",     32'(busy),        0);
    chk("rstmid_start",    32'(drv_start),   0);
    chk("rstmid_data_in",  32'(drv_data_in), 0);
    chk("rstmid_err",      32'(err_timeout), 0);
    chk("rstmid_rx_valid", 32'(rx_valid),    0);
    chk("rstmid_tx_ready", 32'(tx_ready),    1);
    chk("rstmid_tx_level", 32'(tx_level),    0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rstmid_no_push",   32'(rx_valid), 0);
    chk("rstmid_no_launch", start_cnt, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
